// File: rtl/eggtimer_ctrl.sv
// eggtimer_ctrl
//   Countdown control stage of the egg timer. Edge-detects the debounced
//   button levels, lets the user set MM:SS in IDLE, then counts down once
//   per tick_1s while running, with pause/resume and an auto-clearing alarm
//   at 00:00. The time is held directly as BCD digits for the display.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-high reset to IDLE / 00:00
//   tick_1s    one-clk enable pulse per second
//   sec_btn    debounced seconds-set level
//   min_btn    debounced minutes-set level
//   start_btn  debounced start/pause level
//   sec_tens   seconds tens digit (0..5)
//   sec_ones   seconds ones digit (0..9)
//   min_tens   minutes tens digit (0..9)
//   min_ones   minutes ones digit (0..9)
//   running    high in RUN
//   alarm      high in ALARM
module eggtimer_ctrl #(
  parameter int unsigned ALARM_SECS = 10  // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       sec_btn,
  input  logic       min_btn,
  input  logic       start_btn,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

  state_e     state_q, state_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       sec_prev_q, min_prev_q, start_prev_q;

  logic sec_ev, min_ev, start_ev;
  logic time_zero, time_one;

  // Prev registers reset to 0, so a button held through reset produces
  // one event on the first edge after release.
  assign sec_ev   = sec_btn   & ~sec_prev_q;
  assign min_ev   = min_btn   & ~min_prev_q;
  assign start_ev = start_btn & ~start_prev_q;

  assign time_zero = (sec_tens_q == 3'd0) && (sec_ones_q == 4'd0) &&
                     (min_tens_q == 4'd0) && (min_ones_q == 4'd0);
  assign time_one  = (sec_tens_q == 3'd0) && (sec_ones_q == 4'd1) &&
                     (min_tens_q == 4'd0) && (min_ones_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    alarm_cnt_d = alarm_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ev && !time_zero) begin
          // set events in the same cycle are dropped on the way to RUN
          state_d = S_RUN;
        end else begin
          if (sec_ev) begin
            // seconds wrap 59 -> 00 without touching minutes
            if (sec_ones_q == 4'd9) begin
              sec_ones_d = 4'd0;
              sec_tens_d = (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
            end else begin
              sec_ones_d = sec_ones_q + 4'd1;
            end
          end
          if (min_ev) begin
            if (min_ones_q == 4'd9) begin
              min_ones_d = 4'd0;
              min_tens_d = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
            end else begin
              min_ones_d = min_ones_q + 4'd1;
            end
          end
        end
      end

      S_RUN: begin
        if (start_ev) begin
          // pause wins over a coincident tick
          state_d = S_PAUSE;
        end else if (tick_1s) begin
          if (time_one) state_d = S_ALARM;
          if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
          end else begin
            sec_ones_d = 4'd9;
            if (sec_tens_q != 3'd0) begin
              sec_tens_d = sec_tens_q - 3'd1;
            end else begin
              // :00 -> :59 borrows a minute; RUN is never entered at 00:00
              sec_tens_d = 3'd5;
              if (min_ones_q != 4'd0) begin
                min_ones_d = min_ones_q - 4'd1;
              end else begin
                min_ones_d = 4'd9;
                min_tens_d = min_tens_q - 4'd1;
              end
            end
          end
        end
      end

      S_PAUSE: begin
        if (start_ev) begin
          state_d = S_RUN;
        end else if (sec_ev || min_ev) begin
          state_d    = S_IDLE;
          sec_tens_d = 3'd0;
          sec_ones_d = 4'd0;
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
        end
      end

      S_ALARM: begin
        if (start_ev) begin
          state_d     = S_IDLE;
          alarm_cnt_d = 8'd0;
        end else if (tick_1s) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            state_d     = S_IDLE;
            alarm_cnt_d = 8'd0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sec_tens_q   <= 3'd0;
      sec_ones_q   <= 4'd0;
      min_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      alarm_cnt_q  <= 8'd0;
      sec_prev_q   <= 1'b0;
      min_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      min_tens_q   <= min_tens_d;
      min_ones_q   <= min_ones_d;
      alarm_cnt_q  <= alarm_cnt_d;
      sec_prev_q   <= sec_btn;
      min_prev_q   <= min_btn;
      start_prev_q <= start_btn;
    end
  end

  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign running  = (state_q == S_RUN);
  assign alarm    = (state_q == S_ALARM);

endmodule

// File: doc/eggtimer_ctrl.md
# eggtimer_ctrl

Countdown control stage for the egg timer. Sits directly downstream of the button debouncers: it consumes their debounced levels, edge-detects them, and uses them to set a MM:SS time, start, pause and clear the countdown. It decrements once per 1 s clock-enable tick and raises an alarm at 00:00. Outputs are BCD digits for the display driver plus status flags.

## Interface
Parameters:
- ALARM_SECS, 10: number of 1 s ticks the alarm stays asserted before auto-clearing; legal 1..255.

Ports:
- clk  input  1  system clock (1 kHz); all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- tick_1s  input  1  one-clk-wide enable pulse, once per second.
- sec_btn  input  1  debounced seconds-set button level.
- min_btn  input  1  debounced minutes-set button level.
- start_btn  input  1  debounced start/pause button level.
- sec_tens  output  3  seconds tens digit, 0..5.
- sec_ones  output  4  seconds ones digit, 0..9.
- min_tens  output  4  minutes tens digit, 0..9.
- min_ones  output  4  minutes ones digit, 0..9.
- running  output  1  high while counting down.
- alarm  output  1  high while in ALARM.

## Operation
- Edge detect: each button has a previous-value register, reset to 0. The event is in & ~prev. A held button yields exactly one event. A button already high when reset deasserts yields one event.
- States: IDLE, RUN, PAUSE, ALARM. Reset state is IDLE with time 00:00, running=0, alarm=0, alarm tick counter=0.
- IDLE:
  - sec event: seconds +1 in BCD, wrapping 59->00 with no carry into minutes.
  - min event: minutes +1 in BCD, wrapping 99->00.
  - sec and min events in the same cycle: both apply.
  - start event with time != 00:00: go to RUN. Sec/min events in that same cycle are ignored.
  - start event with time == 00:00: stay in IDLE, no effect.
- RUN (running=1):
  - tick: decrement time. ones 0 borrows from tens. seconds 00 becomes 59 and borrows one minute.
  - Decrement from 00:01 reaches 00:00 and enters ALARM on the same edge.
  - start event: go to PAUSE. If a tick coincides, the start event wins and the tick is dropped.
  - sec/min events are ignored.
- PAUSE:
  - Time is frozen and ticks are ignored.
  - start event: go to RUN.
  - sec or min event: clear time to 00:00 and go to IDLE. If start coincides with sec/min, start wins.
- ALARM (alarm=1, time 00:00):
  - Each tick increments the alarm counter.
  - When the counter reaches ALARM_SECS, go to IDLE.
  - start event: go to IDLE immediately.
  - Counter clears on every exit from ALARM.
  - sec/min events are ignored.
- Ticks in IDLE are ignored.
- All digits are held in BCD registers; no binary-to-BCD conversion.

## Timing
- All outputs are registered. running and alarm are decoded from the state register, with no combinational path from the inputs.
- Latency: an input high at rising edge k (prev=0) updates state/time at edge k.
- tick_1s is sampled only on clk edges; its width is assumed to be exactly 1 clk.
- Reset mid-RUN or mid-ALARM: immediate return to the IDLE/00:00 reset values. Events pending at reset are lost.
- Max countdown 99:59 = 5999 ticks. Decrement never underflows, because RUN is never entered at 00:00.

## Test plan
- Reset, then 61 sec_btn pulses -> 00:01 (wrap at 60th pulse). 101 min_btn pulses -> 01:01.
- Set 00:03, press start, apply 3 ticks -> 00:02, 00:01, then 00:00 with alarm=1 and running=0 on the third tick edge. After 10 more ticks -> alarm=0, state IDLE.
- Set 01:00, start, 1 tick -> 00:59. Press start -> running=0. 5 ticks -> still 00:59. Press start -> resumes, next tick gives 00:58.
- In PAUSE at 00:58, press min_btn -> time 00:00, state IDLE. Press start -> remains IDLE, running=0.
- In RUN at 00:10, assert start_btn and tick_1s in the same cycle -> PAUSE at 00:10. In IDLE, assert sec and min together from 00:00 -> 01:01.
- Hold start_btn high for 500 clks from IDLE at 00:05 -> single transition to RUN. Assert reset asynchronously mid-count -> all outputs 0 before the next clk edge.
